// File: rtl/pmem_pkg.sv
// Shared types and constants for the physical-memory burst responder.
// A cache line is four 64-bit beats; beat 0 holds bytes [7:0] of the line.
package pmem_pkg;

  localparam int unsigned BEAT_W         = 64;
  localparam int unsigned BEATS_PER_LINE = 4;
  localparam int unsigned LINE_OFFSET_W  = 5;
  localparam int unsigned BEAT_IDX_W     = 2;
  localparam int unsigned LAT_CNT_W      = 8;

  typedef logic [BEAT_W-1:0]     pmem_beat_t;
  typedef logic [BEAT_IDX_W-1:0] pmem_beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } pmem_rsp_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_e;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port, beat-addressable line storage with a registered read port.
// The read register only updates when re is high, so it holds otherwise.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDX_W+BEAT_IDX_W-1:0] addr,
  input  logic                        we,
  input  logic                        re,
  input  pmem_beat_t                  wdata,
  output pmem_beat_t                  rdata
);

  pmem_beat_t mem_q [DEPTH_LINES*BEATS_PER_LINE];
  pmem_beat_t rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset, so it maps onto block RAM and a
  // burst aborted by reset leaves its already-written beats in place.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// Line-burst memory responder: accepts a read/write line request, waits
// LATENCY cycles, then streams four 64-bit beats with mem_resp high.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
    (LATENCY > 0) ? LAT_CNT_W'(LATENCY - 1) : '0;

  pmem_rsp_state_e      state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  pmem_beat_idx_t       beat_q, beat_d;
  pmem_beat_idx_t       beat_nxt;
  logic [IDX_W-1:0]     line_q, line_d;
  pmem_op_e             op_q, op_d;

  logic [IDX_W-1:0]            req_line;
  logic [IDX_W+BEAT_IDX_W-1:0] arr_addr;
  logic                        arr_we;
  logic                        arr_re;
  logic                        unused_addr_bits;

  // Offset bits and bits above the line index are dropped, so addresses wrap.
  assign req_line         = mem_addr[LINE_OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{mem_addr[31:LINE_OFFSET_W+IDX_W],
                              mem_addr[LINE_OFFSET_W-1:0]};
  assign beat_nxt         = beat_q + 2'd1;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    line_d    = line_q;
    op_d      = op_q;
    mem_resp  = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = {line_q, beat_q};

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          line_d = req_line;
          op_d   = mem_read ? OP_READ : OP_WRITE;
          beat_d = '0;
          if (LATENCY == 0) begin
            // Zero latency: the storage read for beat 0 issues right now.
            state_d  = BURST;
            arr_re   = mem_read;
            arr_addr = {req_line, 2'd0};
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
          end
        end
      end

      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d  = BURST;
          arr_re   = (op_q == OP_READ);
          arr_addr = {line_q, 2'd0};
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      BURST: begin
        mem_resp = 1'b1;
        if (op_q == OP_WRITE) begin
          arr_we = 1'b1;
        end else if (beat_q != 2'd3) begin
          // Prefetch the next beat so it is registered for the next cycle.
          arr_re   = 1'b1;
          arr_addr = {line_q, beat_nxt};
        end
        beat_d = beat_nxt;
        if (beat_q == 2'd3) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      op_q      <= OP_READ;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      op_q      <= op_d;
    end
  end

  pmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_line_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (arr_addr),
    .we    (arr_we),
    .re    (arr_re),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Simultaneous read and write requests are illegal; the read would win.
  a_no_dual_request : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !(mem_read && mem_write)
  );

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench for pmem_burst_responder: one instance at LATENCY=10 and
// one at LATENCY=0; a negedge monitor pops expected beats as mem_resp fires.
module tb_pmem_burst_responder;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic        resp  [2];
  logic [63:0] rdata [2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_burst_responder #(.LATENCY(10), .DEPTH_LINES(256)) dut (
    .clk       (clk),
    .rst       (rst[0]),
    .mem_read  (rd[0]),
    .mem_write (wr[0]),
    .mem_addr  (addr[0]),
    .mem_wdata (wdata[0]),
    .mem_resp  (resp[0]),
    .mem_rdata (rdata[0])
  );

  pmem_burst_responder #(.LATENCY(0), .DEPTH_LINES(256)) dut0 (
    .clk       (clk),
    .rst       (rst[1]),
    .mem_read  (rd[1]),
    .mem_write (wr[1]),
    .mem_addr  (addr[1]),
    .mem_wdata (wdata[1]),
    .mem_resp  (resp[1]),
    .mem_rdata (rdata[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   depth;
    if (resp[s] === 1'b1) begin
      depth = (s == 0) ? q0.size() : q1.size();
      if (depth == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resp dut%0d: resp=1 at cycle %0d, expected 0", s, cyc);
      end else begin
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("resp_cycle dut%0d", s), 64'(cyc), 64'(e.cyc));
        if (e.chk_data)
          check($sformatf("rdata dut%0d cycle %0d", s, e.cyc), rdata[s], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Issues one request, queues the expected beats and follows mem_resp.
  // nbeats=8 keeps the request held across two bursts; drop_after sets how
  // many beats are seen before the request is released.
  task automatic xfer(input int s, input bit is_wr, input logic [31:0] a,
                      input logic [63:0] b0, input logic [63:0] b1,
                      input logic [63:0] b2, input logic [63:0] b3,
                      input int lat, input int nbeats, input int drop_after);
    logic [63:0] b [4];
    exp_t        e;
    int          c0;
    int          n;
    int          budget;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    @(posedge clk); #1;
    c0       = cyc;
    addr[s]  = a;
    wdata[s] = b[0];
    if (is_wr) wr[s] = 1'b1;
    else       rd[s] = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      e.cyc      = c0 + lat + 1 + (k % 4) + (k / 4) * (lat + 6);
      e.data     = b[k % 4];
      e.chk_data = !is_wr;
      push(s, e);
    end
    n      = 0;
    budget = 0;
    while (n < nbeats && budget < 100) begin
      @(negedge clk);
      budget++;
      if (resp[s] === 1'b1) begin
        n++;
        @(posedge clk); #1;
        wdata[s] = b[n % 4];
        if (n >= drop_after) begin
          rd[s] = 1'b0;
          wr[s] = 1'b0;
        end
      end
    end
    if (n < nbeats) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h: %0d beats seen, %0d required", s, a, n, nbeats);
      rd[s] = 1'b0;
      wr[s] = 1'b0;
    end
  endtask

  localparam logic [63:0] P0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] P2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] P3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_00A0;
  localparam logic [63:0] A1 = 64'hA1A1_0000_0000_00A1;
  localparam logic [63:0] A2 = 64'hA2A2_0000_0000_00A2;
  localparam logic [63:0] A3 = 64'hA3A3_0000_0000_00A3;
  localparam logic [63:0] B0 = 64'hB000_0000_0000_0B00;
  localparam logic [63:0] B1 = 64'hB111_0000_0000_0B11;
  localparam logic [63:0] B2 = 64'hB222_0000_0000_0B22;
  localparam logic [63:0] B3 = 64'hB333_0000_0000_0B33;
  localparam logic [63:0] C0 = 64'hC0C0_C0C0_0000_0001;
  localparam logic [63:0] C1 = 64'hC1C1_C1C1_0000_0002;
  localparam logic [63:0] E0 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] E1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] E2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] E3 = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] D3 = 64'hFFFF_0000_FFFF_0000;

  initial begin
    int   c0;
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      rst[s]   = 1'b1;
      rd[s]    = 1'b0;
      wr[s]    = 1'b0;
      addr[s]  = '0;
      wdata[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check("reset_resp dut0", 64'(resp[0]), 64'd0);
    check("reset_rdata dut0", rdata[0], 64'd0);
    check("reset_resp dut1", 64'(resp[1]), 64'd0);
    check("reset_rdata dut1", rdata[1], 64'd0);

    // Preload line 0x40, read it back at LATENCY=10 (beats in cycles 11..14).
    xfer(0, 1'b1, 32'h0000_0040, P0, P1, P2, P3, 10, 4, 4);
    xfer(0, 1'b0, 32'h0000_0040, P0, P1, P2, P3, 10, 4, 4);
    repeat (2) @(posedge clk);
    #1;
    check("rdata_hold_after_burst", rdata[0], P3);

    // Write then read line 0x100; offset bits of 0x11F are ignored.
    xfer(0, 1'b1, 32'h0000_0100, A0, A1, A2, A3, 10, 4, 4);
    xfer(0, 1'b0, 32'h0000_0100, A0, A1, A2, A3, 10, 4, 4);
    xfer(0, 1'b0, 32'h0000_011F, A0, A1, A2, A3, 10, 4, 4);

    // Read request released in cycle 12; the burst still completes.
    xfer(0, 1'b0, 32'h0000_0040, P0, P1, P2, P3, 10, 4, 1);

    // Reset in cycle 12 of a write leaves new beats 0-1 and old beats 2-3.
    xfer(0, 1'b1, 32'h0000_0180, B0, B1, B2, B3, 10, 4, 4);
    @(posedge clk); #1;
    c0       = cyc;
    addr[0]  = 32'h0000_0180;
    wdata[0] = C0;
    wr[0]    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e.cyc      = c0 + 11 + k;
      e.data     = '0;
      e.chk_data = 1'b0;
      push(0, e);
    end
    repeat (12) @(posedge clk);
    #1;
    wdata[0] = C1;
    wr[0]    = 1'b0;
    rst[0]   = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("abort_resp_low", 64'(resp[0]), 64'd0);
    check("abort_rdata_reset", rdata[0], 64'd0);
    xfer(0, 1'b0, 32'h0000_0180, C0, C1, B2, B3, 10, 4, 4);

    // Address wrap: 0x2000 aliases line 0 with 256 lines.
    xfer(0, 1'b1, 32'h0000_0000, E0, E1, E2, E3, 10, 4, 4);
    xfer(0, 1'b0, 32'h0000_2000, E0, E1, E2, E3, 10, 4, 4);

    // LATENCY=0: beats in cycles 1..4; a held request re-accepts in cycle 6.
    xfer(1, 1'b1, 32'h0000_0060, D0, D1, D2, D3, 0, 4, 4);
    xfer(1, 1'b0, 32'h0000_0060, D0, D1, D2, D3, 0, 8, 8);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained dut0", 64'(q0.size()), 64'd0);
    check("scoreboard_drained dut1", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
